muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers. It runs in
//  the EX stage beside the ALU and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Generalises fixed 32-bit HI/LO writes to parametrised width and radix, with
//  multi-cycle ops, a busy/done handshake and abort-on-flush.
// PARAMETERS
//  WIDTH          32  operand width; HI and LO are WIDTH bits each
//  BITS_PER_CYCLE 1   multiplier/quotient bits retired per RUN cycle; must divide WIDTH
// PORTS
//  clk     in   1      clock; all state updates on rising edge
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      op request; sampled only when busy=0
//  op      in   3      muldiv_pkg::md_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  a       in   WIDTH  rs operand (dividend / multiplicand / MTHI, MTLO data)
//  b       in   WIDTH  rt operand (divisor / multiplier)
//  abort   in   1      flushE: cancel in-flight op
//  busy    out  1      state!=IDLE; hazard unit stalls any HI/LO access on it
//  done    out  1      1-cycle pulse; HI/LO hold the new result in the same cycle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, all datapath regs 0.
//  - FSM IDLE->RUN->FIX->IDLE. STEPS=WIDTH/BITS_PER_CYCLE.
//  - IDLE, start=1, abort=0, op MULT/MULTU/DIV/DIVU: latch |a|, |b| and result signs.
//    |a|, |b| apply to signed ops only. Then go to RUN.
//  - IDLE, start=1, op MTHI/MTLO: write a to hi or lo at that edge. State stays IDLE;
//    busy never rises; done=0.
//  - RUN: shift-add multiply or restoring divide, BITS_PER_CYCLE steps per cycle.
//    After STEPS cycles go to FIX.
//  - FIX: apply sign fix-up and write hi/lo at its closing edge. done=1 in the
//    following cycle (IDLE).
//  - Latency (macro off): start sampled at edge E0; done and new hi/lo are visible
//    STEPS+1 cycles later (33 for default params). busy=1 for STEPS+1 cycles.
//    A new start is accepted in the done cycle (back-to-back).
//  - start while busy=1: ignored, no queueing.
//  - abort=1 in any state: next state IDLE, no done, hi/lo unchanged.
//    abort has priority over a coincident start. An abort in FIX suppresses the write.
//  - Multiply: 2*WIDTH product, hi=upper half, lo=lower half. Signed result is the
//    negated magnitude when the operand signs differ.
//  - Divide: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
//  - Divide by zero (DIV and DIVU): lo={WIDTH{1}}, hi=a. Full latency still applies.
//  - Signed overflow MIN/-1: lo=MIN, hi=0. This falls out of the abs/negate datapath.
//  - Widths: internal accumulator is 2*WIDTH+1 bits; no truncation before FIX.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: in RUN for MULT/MULTU, if the remaining multiplier
//    shift register is 0 after this cycle's step, go to FIX next. Minimum is 1 RUN
//    cycle. Divides are unaffected.
//  Not defined: every multiply takes exactly STEPS RUN cycles. Latency is fixed.
// STRUCTURE
//  - muldiv_pkg: md_op_t enum, md_state_t {IDLE,RUN,FIX}, and a function
//    steps(WIDTH,BPC). Shared with the controller and hazard unit.
//  - Sub-module muldiv_step: combinational single-bit shift-add/restoring step.
//    Instantiated BITS_PER_CYCLE times in a generate chain.
// TESTING (WIDTH=32, BITS_PER_CYCLE=1 unless noted)
//  1. MULT a=FFFFFFFD b=00000007 -> done 33 cycles after start; hi=FFFFFFFF lo=FFFFFFEB.
//  2. DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//  3. DIVU a=0000000A b=0 -> lo=FFFFFFFF, hi=0000000A, done at 33 cycles.
//  4. DIVU started, abort at RUN cycle 5 -> busy=0 next cycle, no done, hi/lo keep old values.
//     A start at RUN cycle 3 (before the abort) is ignored.
//  5. MTHI a=12345678 -> hi=12345678 next cycle, busy stays 0.
//     Reset driven low mid-MULTU -> busy=0, done=0, hi=lo=0 immediately.
//  6. MULTU 3*5 with MULDIV_EARLY_OUT_EN -> done 4 cycles after start, lo=0000000F, hi=0.
//     Without the macro, done comes at 33. Repeat test 1 with BITS_PER_CYCLE=4 -> done at 9.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//  Shared types for the iterative multiply/divide unit. The controller and the
//  hazard unit also use these types.
//  md_op_t    : operation code driven on muldiv_unit.op
//  md_state_t : controller state (IDLE -> RUN -> FIX -> IDLE)
//  steps()    : number of RUN cycles for a given width and bits-per-cycle
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // bpc must divide width exactly.
    function automatic int steps(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//  Combinational single-bit iteration shared by multiply and divide.
//  Multiply (i_div=0): acc += y[0] ? x : 0;  x <<= 1;  y >>= 1
//    x holds the multiplicand shifted left, y the remaining multiplier bits.
//  Divide (i_div=1): restoring step. acc[WIDTH-1:0] holds the partial
//    remainder, y shifts the dividend out of its MSB while quotient bits
//    shift in at its LSB, x[WIDTH-1:0] holds the divisor.
// Ports
//  i_div           : 1 = divide step, 0 = multiply step
//  i_acc / o_acc   : 2*WIDTH+1 accumulator in / out
//  i_x   / o_x     : 2*WIDTH multiplicand-or-divisor in / out
//  i_y   / o_y     : WIDTH multiplier-or-dividend/quotient in / out
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH:0]     i_acc,
    input  logic [2*WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]     i_y,
    output logic [2*WIDTH:0]     o_acc,
    output logic [2*WIDTH-1:0]   o_x,
    output logic [WIDTH-1:0]     o_y
);

    logic [WIDTH:0]     w_trial;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_addend;

    always_comb begin
        // The partial remainder is always below the divisor, so the trial
        // value fits in WIDTH+1 bits; the extra MSB of w_diff is the borrow.
        w_trial  = {i_acc[WIDTH-1:0], i_y[WIDTH-1]};
        w_diff   = {1'b0, w_trial} - {2'b00, i_x[WIDTH-1:0]};
        w_qbit   = ~w_diff[WIDTH+1];
        w_addend = i_y[0] ? i_x : {(2*WIDTH){1'b0}};

        if (i_div) begin
            o_acc = {{WIDTH{1'b0}}, (w_qbit ? w_diff[WIDTH:0] : w_trial)};
            o_x   = i_x;
            o_y   = {i_y[WIDTH-2:0], w_qbit};
        end else begin
            o_acc = i_acc + {1'b0, w_addend};
            o_x   = {i_x[2*WIDTH-2:0], 1'b0};
            o_y   = {1'b0, i_y[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//  Iterative multiply/divide unit with architectural HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU over STEPS=WIDTH/BITS_PER_CYCLE RUN cycles
//  plus one FIX cycle for sign correction; MTHI/MTLO write directly from IDLE.
//  Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN
//  as soon as the remaining multiplier bits are all zero.
// Ports
//  clk    : clock, rising edge
//  reset  : asynchronous active-low reset
//  start  : op request, sampled only while idle
//  op     : md_op_t operation
//  a, b   : rs / rt operands
//  abort  : cancel any in-flight op (priority over start)
//  busy   : unit occupied (state != IDLE)
//  done   : one-cycle pulse, hi/lo already hold the new result
//  hi, lo : HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = $clog2(STEPS + 1);

    md_state_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH-1:0] r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_is_div;
    logic               r_neg_q;   // negate product / quotient
    logic               r_neg_r;   // negate remainder (dividend was negative)
    logic               r_div0;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // ---------------- operand decode ----------------
    logic             w_is_signed;
    logic             w_is_div;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_is_signed = (op == MULT) || (op == DIV);
    assign w_is_div    = (op == DIV)  || (op == DIVU);
    assign w_a_mag     = (w_is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (w_is_signed && b[WIDTH-1]) ? -b : b;

    // ---------------- step chain ----------------
    logic [2*WIDTH:0]   w_acc [0:BITS_PER_CYCLE];
    logic [2*WIDTH-1:0] w_x   [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0]   w_y   [0:BITS_PER_CYCLE];

    assign w_acc[0] = r_acc;
    assign w_x[0]   = r_x;
    assign w_y[0]   = r_y;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            muldiv_step #(.WIDTH(WIDTH)) u_step (
                .i_div (r_is_div),
                .i_acc (w_acc[gi]),
                .i_x   (w_x[gi]),
                .i_y   (w_y[gi]),
                .o_acc (w_acc[gi+1]),
                .o_x   (w_x[gi+1]),
                .o_y   (w_y[gi+1])
            );
        end
    endgenerate

    // ---------------- RUN exit ----------------
    logic w_last;
`ifdef MULDIV_EARLY_OUT_EN
    // Once the multiplier is exhausted every further step adds zero.
    assign w_last = (r_cnt == CW'(STEPS - 1)) ||
                    (!r_is_div && (w_y[BITS_PER_CYCLE] == '0));
`else
    assign w_last = (r_cnt == CW'(STEPS - 1));
`endif

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_hi_new;
    logic [WIDTH-1:0]   w_lo_new;

    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_rem      = r_acc[WIDTH-1:0];
    // Divide by zero leaves an all-ones quotient; keep it regardless of sign.
    assign w_q_fix    = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_y : r_y);
    assign w_r_fix    = r_neg_r ? -w_rem : w_rem;
    assign w_hi_new   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_new   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                MTHI: r_hi <= a;
                                MTLO: r_lo <= a;
                                MULT, MULTU, DIV, DIVU: begin
                                    r_state  <= RUN;
                                    r_cnt    <= '0;
                                    r_acc    <= '0;
                                    r_is_div <= w_is_div;
                                    r_x      <= {{WIDTH{1'b0}}, (w_is_div ? w_b_mag : w_a_mag)};
                                    r_y      <= w_is_div ? w_a_mag : w_b_mag;
                                    r_neg_q  <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    r_neg_r  <= w_is_signed && w_is_div && a[WIDTH-1];
                                    r_div0   <= w_is_div && (b == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    RUN: begin
                        r_acc <= w_acc[BITS_PER_CYCLE];
                        r_x   <= w_x[BITS_PER_CYCLE];
                        r_y   <= w_y[BITS_PER_CYCLE];
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state <= FIX;
                        end
                    end
                    FIX: begin
                        r_hi    <= w_hi_new;
                        r_lo    <= w_lo_new;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//  Directed and random stimulus for muldiv_unit against a plain-arithmetic
//  reference model. A second instance with BITS_PER_CYCLE=4 checks the
//  shortened latency. Honours MULDIV_EARLY_OUT_EN when computing latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    md_op_t       op    = MULT;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    logic         start4 = 1'b0;
    logic         abort4 = 1'b0;
    md_op_t       op4    = MULT;
    logic [W-1:0] a4     = '0;
    logic [W-1:0] b4     = '0;
    logic         busy4, done4;
    logic [W-1:0] hi4, lo4;

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4),
        .abort(abort4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference results from ordinary arithmetic.
    task automatic ref_md(input md_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint      sp, q, r;
        logic [63:0] up;
        rh = exp_hi;
        rl = exp_lo;
        case (o)
            MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                rh = up[63:32];
                rl = up[31:0];
            end
            DIV: begin
                if (y == '0) begin
                    rl = '1;
                    rh = x;
                end else begin
                    q  = longint'($signed(x)) / longint'($signed(y));
                    r  = longint'($signed(x)) % longint'($signed(y));
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
            DIVU: begin
                if (y == '0) begin
                    rl = '1;
                    rh = x;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endtask

    // Active edges from the start-sampling edge to the edge that raises done.
    function automatic int exp_lat(input md_op_t o, input logic [W-1:0] y, input int bpc);
        logic [W-1:0] mag;
        int bl, r;
        r = W / bpc;
        if (EARLY && (o == MULT || o == MULTU)) begin
            mag = (o == MULT && y[W-1]) ? -y : y;
            bl = 0;
            for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
            r = (bl + bpc - 1) / bpc;
            if (r < 1) r = 1;
        end
        return r + 1;
    endfunction

    // Issue an op at the current negedge; returns at the negedge showing done.
    // poke >= 0 drives a conflicting start in that busy cycle.
    task automatic run_op(input md_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag, input int poke);
        int lat, busy_cnt, el;
        logic [W-1:0] rh, rl;
        ref_md(o, x, y, rh, rl);
        el = exp_lat(o, y, 1);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        chk({tag, " done_first_cycle"}, {63'b0, done}, 64'd0);
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == poke) begin
                op = MULTU; a = ~x; b = ~y; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(el));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(el));
        chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
        chk({tag, " hi"}, {32'b0, hi}, {32'b0, rh});
        chk({tag, " lo"}, {32'b0, lo}, {32'b0, rl});
        $display("op=%s a=%h b=%h lat=%0d hi=%h lo=%h", o.name(), x, y, lat, hi, lo);
        exp_hi = rh;
        exp_lo = rl;
    endtask

    task automatic mt_op(input md_op_t o, input logic [W-1:0] x, input string tag);
        op = o; a = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (o == MTHI) exp_hi = x; else exp_lo = x;
        chk({tag, " hi"}, {32'b0, hi}, {32'b0, exp_hi});
        chk({tag, " lo"}, {32'b0, lo}, {32'b0, exp_lo});
        chk({tag, " busy"}, {63'b0, busy}, 64'd0);
        chk({tag, " done"}, {63'b0, done}, 64'd0);
        $display("op=%s a=%h hi=%h lo=%h", o.name(), x, hi, lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        bit seen_done;
        logic [W-1:0] rh, rl, x, y;
        md_op_t o;

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset hi", {32'b0, hi}, 64'd0);
        chk("reset lo", {32'b0, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- directed, back to back ----------------
        run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0007, "t1_mult", -1);
        run_op(DIV,  32'hFFFF_FFF9, 32'h0000_0002, "t2_div", -1);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "t2_ovf", -1);
        run_op(DIVU, 32'h0000_000A, 32'h0000_0000, "t3_divu0", -1);
        run_op(DIV,  32'hFFFF_FFF0, 32'h0000_0000, "div0_neg", -1);
        run_op(MULTU, 32'd3, 32'd5, "t6_multu_poke", 2);

        // ---------------- abort ----------------
        @(negedge clk);
        op = DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);                       // RUN cycle 1
        start = 1'b0;
        @(negedge clk);                       // RUN cycle 2
        @(negedge clk);                       // RUN cycle 3: ignored start
        op = MULT; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);                       // RUN cycle 4
        start = 1'b0;
        chk("abort busy_before", {63'b0, busy}, 64'd1);
        @(negedge clk);                       // RUN cycle 5
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy_after", {63'b0, busy}, 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("abort no_done", {63'b0, seen_done}, 64'd0);
        chk("abort hi", {32'b0, hi}, {32'b0, exp_hi});
        chk("abort lo", {32'b0, lo}, {32'b0, exp_lo});
        $display("op=ABORT hi=%h lo=%h", hi, lo);

        // abort beats a coincident start in IDLE
        op = MTHI; a = 32'hDEAD_BEEF; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start hi", {32'b0, hi}, {32'b0, exp_hi});
        chk("abort_vs_start busy", {63'b0, busy}, 64'd0);
        $display("op=MTHI+ABORT hi=%h", hi);

        // ---------------- MTHI / MTLO ----------------
        mt_op(MTHI, 32'h1234_5678, "t5_mthi");
        mt_op(MTLO, 32'h9ABC_DEF0, "mtlo");

        // ---------------- async reset mid-MULTU ----------------
        op = MULTU; a = 32'h0001_0003; b = 32'h0000_0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid busy", {63'b0, busy}, 64'd0);
        chk("rst_mid done", {63'b0, done}, 64'd0);
        chk("rst_mid hi", {32'b0, hi}, 64'd0);
        chk("rst_mid lo", {32'b0, lo}, 64'd0);
        $display("op=RESET busy=%b hi=%h lo=%h", busy, hi, lo);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- BITS_PER_CYCLE=4 instance ----------------
        ref_md(MULT, 32'hFFFF_FFFD, 32'h0000_0007, rh, rl);
        op4 = MULT; a4 = 32'hFFFF_FFFD; b4 = 32'h0000_0007; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bpc4 latency", 64'(lat), 64'(exp_lat(MULT, 32'h0000_0007, 4)));
        chk("bpc4 hi", {32'b0, hi4}, {32'b0, rh});
        chk("bpc4 lo", {32'b0, lo4}, {32'b0, rl});
        $display("op=MULT(bpc4) lat=%0d hi=%h lo=%h", lat, hi4, lo4);

        // ---------------- random ----------------
        for (int i = 0; i < 30; i++) begin
            o = md_op_t'($urandom_range(0, 5));
            x = pick();
            y = pick();
            if (o == MTHI || o == MTLO) mt_op(o, x, $sformatf("rnd%0d", i));
            else run_op(o, x, y, $sformatf("rnd%0d", i), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
